// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, redirect/stall arbitration and the IF/ID pipeline register.
// Optional feature: define IF_FLUSH_CNT_EN to build a saturating 16-bit redirect counter on
// FlushCnt. Without it, FlushCnt is tied to zero and no counter register exists.
module if_stage #(
    parameter int unsigned PC_W      = 9,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Stall,
    input  logic [31:0]     Instr_in,
    output logic [PC_W-1:0] PC_out,
    output logic [PC_W-1:0] IFID_PC,
    output logic [31:0]     IFID_Instr,
    output logic            IFID_Valid,
    output logic            Misalign,
    output logic [15:0]     FlushCnt
);

    localparam logic [PC_W-1:0] PcInc = PC_W'(4);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic            misalign_q, misalign_d;
    logic            redirect;

    // BrPC bits above PC_W-1 are intentionally dropped.
    logic unused_brpc;
    assign unused_brpc = ^BrPC;

    // Redirects are only honoured once the stage is running.
    assign redirect = (state_q == StRun) && PcSel;

    // Next-state: boot bubble, then redirect beats stall beats sequential fetch.
    always_comb begin
        state_d      = StRun;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        misalign_d   = 1'b0;
        if (state_q == StBoot) begin
            ifid_pc_d    = '0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (PcSel) begin
            pc_d         = {BrPC[PC_W-1:2], 2'b00};
            ifid_pc_d    = '0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            misalign_d   = |BrPC[1:0];
        end else if (!Stall) begin
            pc_d         = pc_q + PcInc;
            ifid_pc_d    = pc_q;
            ifid_instr_d = Instr_in;
            ifid_valid_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StBoot;
            pc_q         <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            misalign_q   <= misalign_d;
        end
    end

`ifdef IF_FLUSH_CNT_EN
    logic [15:0] flush_cnt_q;

    // Count accepted redirects, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flush_cnt_q <= 16'h0000;
        end else if (redirect && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'h0001;
        end
    end

    assign FlushCnt = flush_cnt_q;
`else
    logic unused_redirect;
    assign unused_redirect = redirect;
    assign FlushCnt        = 16'h0000;
`endif

    assign PC_out     = pc_q;
    assign IFID_PC    = ifid_pc_q;
    assign IFID_Instr = ifid_instr_q;
    assign IFID_Valid = ifid_valid_q;
    assign Misalign   = misalign_q;

endmodule
